// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: default widths, the fetch queue entry
// handed to decode, and the queue counter width.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 36;
  localparam int DEF_INSTR_W = 36;
  localparam int FETCH_DEPTH = 4;
  localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from
// storage so decode never sees a combinational path from memory read data.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; count gates validity of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// memory reads, tags responses with their PC and queues them for decode.
// Define FETCH_PERF_EN to add saturating fetched/dropped performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_dec_valid,
  output logic [ADDR_W-1:0]  o_dec_pc,
  output logic [INSTR_W-1:0] o_dec_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0]        o_perf_fetched,
  output logic [31:0]        o_perf_dropped,
`endif
  input  logic               i_dec_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              dropping;
  logic              push;
  logic              pop;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  // Every granted request already owns a queue slot, so responses are never stalled.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign o_imem_req  = !i_rst && !i_redirect && (credit_used < (CNT_W+1)'(DEPTH));
  assign o_imem_addr = fetch_pc;
  assign grant       = o_imem_req && i_imem_gnt;
  assign dropping    = i_imem_rvalid && (drop_cnt != '0);
  assign push        = i_imem_rvalid && !i_redirect && (drop_cnt == '0);
  assign pop         = o_dec_valid && i_dec_ready && !i_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (i_redirect) begin
      // Everything still in flight belongs to the old path and must be dropped.
      fetch_pc    <= i_redirect_pc;
      resp_pc     <= i_redirect_pc;
      outstanding <= outstanding - CNT_W'(i_imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(i_imem_rvalid);
    end else begin
      if (grant) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (push)  resp_pc  <= resp_pc + ADDR_W'(1);
      if (dropping) drop_cnt <= drop_cnt - CNT_W'(1);
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(i_imem_rvalid);
    end
  end

  assign push_data = '{pc: resp_pc, instr: i_imem_rdata};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (i_redirect),
    .head      (head),
    .count     (count)
  );

  assign o_dec_valid = (count != '0);
  assign o_dec_pc    = head.pc;
  assign o_dec_instr = head.instr;

`ifdef FETCH_PERF_EN
  logic [CNT_W:0] drop_inc;
  logic [32:0]    fetched_sum;
  logic [32:0]    dropped_sum;

  // Flushed queue entries count as dropped alongside discarded responses.
  assign drop_inc    = (CNT_W+1)'(i_imem_rvalid && (i_redirect || drop_cnt != '0))
                     + (i_redirect ? {1'b0, count} : '0);
  assign fetched_sum = {1'b0, o_perf_fetched} + 33'(pop);
  assign dropped_sum = {1'b0, o_perf_dropped} + 33'(drop_inc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_fetched <= '0;
      o_perf_dropped <= '0;
    end else begin
      o_perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      o_perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a single-cycle in-order memory model;
// perf counter checks are active when FETCH_PERF_EN is defined.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [35:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [35:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [35:0] i_imem_rdata = '0;
  logic        o_dec_valid;
  logic [35:0] o_dec_pc;
  logic [35:0] o_dec_instr;
  logic        i_dec_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_dropped;
`endif

  fetch_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_dec_valid   (o_dec_valid),
    .o_dec_pc      (o_dec_pc),
    .o_dec_instr   (o_dec_instr),
`ifdef FETCH_PERF_EN
    .o_perf_fetched(o_perf_fetched),
    .o_perf_dropped(o_perf_dropped),
`endif
    .i_dec_ready   (i_dec_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit resp_en = 1'b0;
  logic [35:0] pend[$];
  logic [35:0] req_log[$];
  logic [35:0] pop_pc[$];
  logic [35:0] pop_instr[$];
  logic [35:0] ev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set; ends at the next negedge.
  task automatic tick();
    bit was_rst;
    #1;
    was_rst = i_rst;
    if (o_imem_req && i_imem_gnt && !i_rst) begin
      pend.push_back(o_imem_addr);
      req_log.push_back(o_imem_addr);
    end
    if (o_dec_valid && i_dec_ready && !i_redirect && !i_rst) begin
      pop_pc.push_back(o_dec_pc);
      pop_instr.push_back(o_dec_instr);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    if (was_rst) pend.delete();
    if (resp_en && pend.size() > 0) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = pend.pop_front() ^ 36'h5;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
  endtask

  task automatic reset_dut();
    i_rst = 1'b1;
    i_redirect = 1'b0;
    i_imem_gnt = 1'b0;
    i_dec_ready = 1'b0;
    resp_en = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  initial begin
    // streaming, single-cycle memory, decode always ready
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    #1;
    chk("rst_req", 64'(o_imem_req), 64'd0);
    chk("rst_valid", 64'(o_dec_valid), 64'd0);
    reset_dut();
    i_imem_gnt = 1'b1;
    resp_en = 1'b1;
    i_dec_ready = 1'b1;
    #1;
    chk("first_req", 64'(o_imem_req), 64'd1);
    chk("first_addr", 64'(o_imem_addr), 64'd0);
    tick();
    tick();
    #1;
    chk("first_valid", 64'(o_dec_valid), 64'd1);
    chk("first_pc", 64'(o_dec_pc), 64'd0);
    chk("first_instr", 64'(o_dec_instr), 64'd5);
    repeat (8) tick();
    chk("stream_reqs", 64'(req_log.size()), 64'd10);
    chk("stream_pops", 64'(pop_pc.size()), 64'd8);
    for (int i = 0; i < req_log.size(); i++) chk("stream_addr", 64'(req_log[i]), 64'(i));
    for (int i = 0; i < pop_pc.size(); i++) begin
      ev = 36'(i);
      chk("stream_pc", 64'(pop_pc[i]), 64'(ev));
      chk("stream_instr", 64'(pop_instr[i]), 64'(ev ^ 36'h5));
    end

    // decode stalled: queue fills, credits stop requests
    reset_dut();
    i_imem_gnt = 1'b1;
    resp_en = 1'b1;
    repeat (10) tick();
    #1;
    chk("full_reqs", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < req_log.size(); i++) chk("full_addr", 64'(req_log[i]), 64'(i));
    chk("full_req_low", 64'(o_imem_req), 64'd0);
    chk("full_valid", 64'(o_dec_valid), 64'd1);
    chk("full_head_pc", 64'(o_dec_pc), 64'd0);
    i_dec_ready = 1'b1;
    repeat (8) tick();
    chk("drain_pops_ge4", 64'(pop_pc.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) chk("drain_pc", 64'(pop_pc[i]), 64'(i));
    chk("resume_reqs_gt4", 64'(req_log.size() > 4), 64'd1);
    if (req_log.size() > 4) chk("resume_addr", 64'(req_log[4]), 64'd4);

    // grant withheld: request and address hold
    reset_dut();
    resp_en = 1'b1;
    i_dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req", 64'(o_imem_req), 64'd1);
      chk("hold_addr", 64'(o_imem_addr), 64'd0);
      tick();
    end
    i_imem_gnt = 1'b1;
    tick();
    #1;
    chk("hold_grants", 64'(req_log.size()), 64'd1);
    chk("hold_next_addr", 64'(o_imem_addr), 64'd1);

    // redirect with one queued entry and two responses in flight
    reset_dut();
    i_imem_gnt = 1'b1;
    resp_en = 1'b1;
    tick();
    resp_en = 1'b0;
    tick();
    tick();
    i_redirect = 1'b1;
    i_redirect_pc = 36'h100;
    i_dec_ready = 1'b1;
    #1;
    chk("redir_req_low", 64'(o_imem_req), 64'd0);
    tick();
    i_redirect = 1'b0;
    resp_en = 1'b1;
    #1;
    chk("redir_flushed", 64'(o_dec_valid), 64'd0);
    chk("redir_req", 64'(o_imem_req), 64'd1);
    chk("redir_addr", 64'(o_imem_addr), 64'h100);
    repeat (8) tick();
    chk("redir_req_log", 64'(req_log.size() > 3 ? req_log[3] : 36'h0), 64'h100);
    chk("redir_pops", 64'(pop_pc.size()), 64'd4);
    for (int i = 0; i < pop_pc.size(); i++) begin
      ev = 36'h100 + 36'(i);
      chk("redir_pc", 64'(pop_pc[i]), 64'(ev));
      chk("redir_instr", 64'(pop_instr[i]), 64'(ev ^ 36'h5));
    end
`ifdef FETCH_PERF_EN
    chk("perf_dropped", 64'(o_perf_dropped), 64'd3);
    chk("perf_fetched", 64'(o_perf_fetched), 64'(pop_pc.size()));
`endif

    // redirect to the top of the address space: PC wraps to 0
    reset_dut();
    i_imem_gnt = 1'b1;
    resp_en = 1'b1;
    i_dec_ready = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 36'hF_FFFF_FFFF;
    tick();
    i_redirect = 1'b0;
    repeat (6) tick();
    chk("wrap_reqs", 64'(req_log.size()), 64'd6);
    for (int i = 0; i < req_log.size(); i++) begin
      ev = 36'hF_FFFF_FFFF + 36'(i);
      chk("wrap_addr", 64'(req_log[i]), 64'(ev));
    end
    chk("wrap_pops", 64'(pop_pc.size()), 64'd4);
    for (int i = 0; i < pop_pc.size(); i++) begin
      ev = 36'hF_FFFF_FFFF + 36'(i);
      chk("wrap_pc", 64'(pop_pc[i]), 64'(ev));
      chk("wrap_instr", 64'(pop_instr[i]), 64'(ev ^ 36'h5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
